// File: rtl/contador_b_if.sv
// -----------------------------------------------------------------------------
// contador_b_if
// Stimulus/response bundle for the B-counter.
//   enable  count/load enable (driver -> counter)
//   modo    operation select  (driver -> counter)
//   D       parallel load data (driver -> counter)
//   Q       registered count value (counter -> checker)
//   rco     registered ripple-carry/borrow pulse (counter -> checker)
// Modports: master = driver/checker side, slave = counter side.
// -----------------------------------------------------------------------------
interface contador_b_if #(
  parameter int WIDTH = 4
) ();
  logic             enable;
  logic [1:0]       modo;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             rco;

  modport master (output enable, modo, D, input Q, rco);
  modport slave  (input enable, modo, D, output Q, rco);
endinterface

// File: rtl/contador_b.sv
// -----------------------------------------------------------------------------
// contador_b
// Synchronous up/down/step/load counter with a registered ripple-carry pulse,
// cascadable by feeding rco of one stage into enable of the next.
//
// Ports:
//   clk       rising-edge clock
//   reset_L   asynchronous active-low reset (clears Q, rco, wrap_cnt)
//   bus       contador_b_if.slave: enable, modo, D in; Q, rco out
//   wrap_cnt  (only with CONTADOR_B_WRAPCNT_EN) saturating count of rco pulses
//
// modo: 00 up by 1, 01 down by 1, 10 up by STEP, 11 parallel load of D.
// Optional feature macro: CONTADOR_B_WRAPCNT_EN adds the wrap_cnt output.
// -----------------------------------------------------------------------------
module contador_b #(
  parameter int WIDTH = 4,
  parameter int STEP  = 3
) (
  input  logic        clk,
  input  logic        reset_L,
`ifdef CONTADOR_B_WRAPCNT_EN
  contador_b_if.slave bus,
  output logic [7:0]  wrap_cnt
`else
  contador_b_if.slave bus
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

  logic [WIDTH-1:0] r_q;
  logic             r_rco;
  logic [WIDTH-1:0] w_q_next;
  logic             w_rco_next;
  logic [WIDTH:0]   w_step_sum;

  // Extra bit holds the carry that becomes rco in step mode.
  assign w_step_sum = {1'b0, r_q} + (WIDTH + 1)'(STEP);

  always_comb begin
    w_q_next   = r_q;
    w_rco_next = 1'b0;
    if (bus.enable) begin
      case (bus.modo)
        2'b00: begin
          w_q_next   = r_q + 1'b1;
          w_rco_next = (r_q == MAX_VAL);
        end
        2'b01: begin
          w_q_next   = r_q - 1'b1;
          w_rco_next = (r_q == '0);
        end
        2'b10: begin
          w_q_next   = w_step_sum[WIDTH-1:0];
          w_rco_next = w_step_sum[WIDTH];
        end
        default: begin
          // Load never signals a wrap, whatever D is.
          w_q_next   = bus.D;
          w_rco_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_q   <= '0;
      r_rco <= 1'b0;
    end else begin
      r_q   <= w_q_next;
      r_rco <= w_rco_next;
    end
  end

  assign bus.Q   = r_q;
  assign bus.rco = r_rco;

`ifdef CONTADOR_B_WRAPCNT_EN
  logic [7:0] r_wrap_cnt;

  // Counts the same edges that raise rco; sticks at 255 rather than rolling.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wrap_cnt <= 8'd0;
    end else if (w_rco_next && (r_wrap_cnt != 8'hFF)) begin
      r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_contador_b.sv
module tb_contador_b;
  localparam int W    = 4;
  localparam int STEP = 3;

  typedef struct packed {
    logic [W-1:0] q;
    logic         rco;
  } exp_t;

  logic clk = 1'b0;
  logic reset_L;
  contador_b_if #(.WIDTH(W)) bus ();
`ifdef CONTADOR_B_WRAPCNT_EN
  logic [7:0] wrap_cnt;
`endif

  contador_b #(.WIDTH(W), .STEP(STEP)) dut (
    .clk     (clk),
    .reset_L (reset_L),
`ifdef CONTADOR_B_WRAPCNT_EN
    .bus     (bus),
    .wrap_cnt(wrap_cnt)
`else
    .bus     (bus)
`endif
  );

  always #5 clk = ~clk;

  int   tests_run = 0;
  int   failed    = 0;
  exp_t sb[$];
  int   model_q   = 0;
  bit   model_rco = 0;
  int   model_wc  = 0;

  // Reference behaviour, written in plain integer arithmetic.
  task automatic model_step(input bit en, input bit [1:0] m, input bit [W-1:0] d);
    int s;
    model_rco = 0;
    if (en) begin
      case (m)
        2'd0: begin model_rco = (model_q == 15); model_q = (model_q + 1) % 16; end
        2'd1: begin model_rco = (model_q == 0);  model_q = (model_q + 15) % 16; end
        2'd2: begin s = model_q + STEP; model_rco = (s >= 16); model_q = s % 16; end
        default: begin model_q = int'(d); model_rco = 0; end
      endcase
    end
    if (model_rco && model_wc < 255) model_wc++;
  endtask

  // Drive one transaction, push its expectation, then land #1 after the edge.
  task automatic drive(input bit en, input bit [1:0] m, input bit [W-1:0] d);
    exp_t e;
    bus.enable = en;
    bus.modo   = m;
    bus.D      = d;
    model_step(en, m, d);
    e.q   = W'(model_q);
    e.rco = model_rco;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    model_q   = 0;
    model_rco = 0;
    model_wc  = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    exp_t e;
    bus.enable = 1'b1;
    bus.modo   = 2'b00;
    bus.D      = '0;
    reset_L    = 1'b1;
    #2;
    reset_L = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (bus.Q !== 4'h0 || bus.rco !== 1'b0) begin
      failed++;
      $display("FAIL reset_immediate Q=%h rco=%b expected Q=0 rco=0", bus.Q, bus.rco);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.Q !== 4'h0 || bus.rco !== 1'b0) begin
        failed++;
        $display("FAIL reset_hold[%0d] Q=%h rco=%b expected Q=0 rco=0", i, bus.Q, bus.rco);
      end
      $display("[TB] reset cycle %0d Q=%h rco=%b", i, bus.Q, bus.rco);
    end
    @(negedge clk);
    reset_L = 1'b1;
    drive(1'b1, 2'b00, 4'h0);
    e = sb.pop_front();
    tests_run++;
    if (bus.Q !== e.q || bus.Q !== 4'h1 || bus.rco !== e.rco) begin
      failed++;
      $display("FAIL reset_first_edge Q=%h rco=%b expected Q=1 rco=%b", bus.Q, bus.rco, e.rco);
    end
    $display("[TB] post-reset Q=%h rco=%b", bus.Q, bus.rco);
  endtask

  // Directed wrap scenario: a load then three counts, checked against both
  // the scoreboard and the literal sequence expected for that mode.
  task automatic test_wrap(input string name, input bit [1:0] m, input bit [W-1:0] d,
                           input logic [15:0] lit_q, input logic [3:0] lit_rco);
    exp_t e;
    logic [W-1:0] lq;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) ? 2'b11 : m, d);
      e  = sb.pop_front();
      lq = lit_q[15 - 4*i -: 4];
      tests_run++;
      if (bus.Q !== e.q || bus.rco !== e.rco || bus.Q !== lq || bus.rco !== lit_rco[3-i]) begin
        failed++;
        $display("FAIL %s[%0d] Q=%h rco=%b expected Q=%h rco=%b", name, i, bus.Q, bus.rco, lq, lit_rco[3-i]);
      end
      $display("[TB] %s step %0d modo=%0d Q=%h rco=%b", name, i, (i == 0) ? 3 : m, bus.Q, bus.rco);
    end
  endtask

  task automatic test_hold();
    exp_t e;
    drive(1'b1, 2'b11, 4'h7);
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'($urandom_range(0, 3)), 4'($urandom));
      e = sb.pop_front();
      tests_run++;
      if (bus.Q !== e.q || bus.Q !== 4'h7 || bus.rco !== 1'b0) begin
        failed++;
        $display("FAIL hold[%0d] Q=%h rco=%b expected Q=7 rco=0", i, bus.Q, bus.rco);
      end
      $display("[TB] hold %0d Q=%h rco=%b", i, bus.Q, bus.rco);
    end
  endtask

  // Pulse reset_L between edges and check that Q/rco clear with no clock.
  task automatic test_async_reset(input bit [W-1:0] base, input bit [1:0] m);
    exp_t e;
    drive(1'b1, 2'b11, base);
    e = sb.pop_front();
    drive(1'b1, m, base);
    e = sb.pop_front();
    tests_run++;
    if (bus.Q !== e.q || bus.rco !== e.rco) begin
      failed++;
      $display("FAIL async_pre Q=%h rco=%b expected Q=%h rco=%b", bus.Q, bus.rco, e.q, e.rco);
    end
    #2;
    reset_L = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (bus.Q !== 4'h0 || bus.rco !== 1'b0) begin
      failed++;
      $display("FAIL async_reset Q=%h rco=%b expected Q=0 rco=0", bus.Q, bus.rco);
    end
    $display("[TB] async reset Q=%h rco=%b", bus.Q, bus.rco);
    #1;
    reset_L = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    exp_t    e;
    bit      en;
    bit [1:0] m;
    bit [W-1:0] d;
    for (int i = 0; i < 60; i++) begin
      en = ($urandom_range(0, 4) != 0);
      m  = 2'($urandom_range(0, 3));
      d  = 4'($urandom);
      drive(en, m, d);
      e = sb.pop_front();
      tests_run++;
      if (bus.Q !== e.q || bus.rco !== e.rco) begin
        failed++;
        $display("FAIL b2b[%0d] Q=%h rco=%b expected Q=%h rco=%b", i, bus.Q, bus.rco, e.q, e.rco);
      end
      $display("[TB] b2b %0d en=%b modo=%0d D=%h Q=%h rco=%b", i, en, m, d, bus.Q, bus.rco);
    end
  endtask

`ifdef CONTADOR_B_WRAPCNT_EN
  task automatic test_wrapcnt();
    exp_t e;
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if (wrap_cnt !== 8'd0) begin
      failed++;
      $display("FAIL wrapcnt_reset wrap_cnt=%0d expected 0", wrap_cnt);
    end
    #1;
    reset_L = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, 2'b00, 4'h0);
      e = sb.pop_front();
    end
    tests_run++;
    if (wrap_cnt !== 8'(model_wc) || wrap_cnt !== 8'd2) begin
      failed++;
      $display("FAIL wrapcnt_40 wrap_cnt=%0d expected 2", wrap_cnt);
    end
    $display("[TB] wrap_cnt after 40 ups = %0d", wrap_cnt);
    drive(1'b1, 2'b11, 4'hF);
    e = sb.pop_front();
    tests_run++;
    if (wrap_cnt !== 8'd2 || bus.Q !== 4'hF) begin
      failed++;
      $display("FAIL wrapcnt_load wrap_cnt=%0d Q=%h expected 2 F", wrap_cnt, bus.Q);
    end
    $display("[TB] wrap_cnt after load = %0d", wrap_cnt);
    for (int i = 0; i < 16 * 260; i++) begin
      drive(1'b1, 2'b01, 4'h0);
      e = sb.pop_front();
    end
    tests_run++;
    if (wrap_cnt !== 8'd255 || wrap_cnt !== 8'(model_wc)) begin
      failed++;
      $display("FAIL wrapcnt_saturate wrap_cnt=%0d expected 255", wrap_cnt);
    end
    $display("[TB] wrap_cnt after many wraps = %0d", wrap_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_wrap("up_wrap",   2'b00, 4'hE, 16'hEF01, 4'b0010);
    test_wrap("down_wrap", 2'b01, 4'h1, 16'h10FE, 4'b0010);
    test_wrap("step3",     2'b10, 4'hC, 16'hCF25, 4'b0010);
    test_hold();
    test_async_reset(4'h7, 2'b11);
    test_async_reset(4'hE, 2'b10);
    test_wrap("up_max_load", 2'b00, 4'hF, 16'hF012, 4'b0100);
    test_back_to_back();
`ifdef CONTADOR_B_WRAPCNT_EN
    test_wrapcnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
